// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer: opcodes, immediate and ALU codes,
// FSM states, datapath mux selects and the bundled control vector.
package multicycle_control_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_JAL   = 3'b011;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   localparam logic [1:0] A_PC     = 2'b00;
   localparam logic [1:0] A_RS1    = 2'b01;
   localparam logic [1:0] A_OLD_PC = 2'b10;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_FOUR = 2'b01;
   localparam logic [1:0] B_IMM  = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       mdr_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [2:0] imm_sel;
      logic       retire;
   } ctrl_t;

   // All-zero vector doubles as the reset/idle value since IMM_NONE is 0.
   localparam ctrl_t CTRL_IDLE = '0;

   function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3);
      case (opcode)
         OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_JAL: is_legal = 1'b1;
         OPC_BRANCH: is_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
         default:    is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// Combinational decode of sequencer state and IR fields into the datapath control vector.
module mc_output_decode
   import multicycle_control_pkg::*;
(
   input  state_t     state,
   input  logic       run,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      // NOTE: default every field first so no path through the case can infer a latch.
      ctrl = CTRL_IDLE;
      unique case (state)
         S_FETCH: begin
            if (run) begin
               ctrl.mem_req   = 1'b1;
               ctrl.iord      = 1'b0;
               ctrl.alu_src_a = A_PC;
               ctrl.alu_src_b = B_FOUR;
               ctrl.alu_op    = ALU_ADD;
               if (mem_ready) begin
                  ctrl.ir_write = 1'b1;
                  ctrl.pc_write = 1'b1;
                  ctrl.pc_src   = PC_SRC_ALU;
               end
            end
         end
         S_DECODE: begin
            // ALUOut captures old_pc + imm as the branch/jump target.
            ctrl.alu_src_a = A_OLD_PC;
            ctrl.alu_src_b = B_IMM;
            ctrl.alu_op    = ALU_ADD;
            if (opcode == OPC_BRANCH)   ctrl.imm_sel = IMM_B;
            else if (opcode == OPC_JAL) ctrl.imm_sel = IMM_J;
            else                        ctrl.imm_sel = IMM_NONE;
         end
         S_EXEC: begin
            case (opcode)
               OPC_RTYPE: begin
                  ctrl.alu_src_a = A_RS1;
                  ctrl.alu_src_b = B_RS2;
                  ctrl.alu_op    = ALU_FUNCT;
               end
               OPC_ITYPE, OPC_LOAD, OPC_STORE: begin
                  ctrl.alu_src_a = A_RS1;
                  ctrl.alu_src_b = B_IMM;
                  ctrl.alu_op    = ALU_ADD;
                  ctrl.imm_sel   = (opcode == OPC_STORE) ? IMM_S : IMM_I;
               end
               OPC_BRANCH: begin
                  ctrl.alu_src_a = A_RS1;
                  ctrl.alu_src_b = B_RS2;
                  ctrl.alu_op    = ALU_SUB;
                  ctrl.imm_sel   = IMM_B;
                  ctrl.pc_src    = PC_SRC_ALUOUT;
                  ctrl.pc_write  = ((funct3 == 3'b000) &&  zero) ||
                                   ((funct3 == 3'b001) && !zero);
                  ctrl.retire    = 1'b1;
               end
               OPC_JAL: begin
                  // PC already holds old_pc + 4, which becomes the link value.
                  ctrl.imm_sel   = IMM_J;
                  ctrl.alu_op    = ALU_JAL;
                  ctrl.pc_write  = 1'b1;
                  ctrl.pc_src    = PC_SRC_ALUOUT;
                  ctrl.reg_write = 1'b1;
                  ctrl.wb_sel    = WB_PC;
                  ctrl.retire    = 1'b1;
               end
               default: ctrl = CTRL_IDLE;
            endcase
         end
         S_MEM: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
            ctrl.mem_we  = (opcode == OPC_STORE);
            if (mem_ready) begin
               if (opcode == OPC_LOAD) ctrl.mdr_write = 1'b1;
               else                    ctrl.retire    = 1'b1;
            end
         end
         S_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = (opcode == OPC_LOAD) ? WB_MDR : WB_ALUOUT;
            ctrl.retire    = 1'b1;
         end
         default: ctrl = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the shared RV32 datapath: state register, next-state logic,
// sticky illegal flag, and the output decode instance.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_write,
   output logic        mdr_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_op,
   output logic [2:0]  imm_sel,
   output logic        retire,
   output logic        illegal,
   output logic [2:0]  state_o,
   output logic [31:0] pc_reset_val
);

   state_t state, state_next;
   ctrl_t  dec_ctrl, ctrl;

   // NOTE: sequential state uses non-blocking assignments; reset is asynchronous, active-low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_DECODE && !is_legal(opcode, funct3))
            illegal <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_FETCH:  if (run && mem_ready) state_next = S_DECODE;
         S_DECODE: state_next = is_legal(opcode, funct3) ? S_EXEC : S_HALT;
         S_EXEC: begin
            case (opcode)
               OPC_RTYPE, OPC_ITYPE: state_next = S_WB;
               OPC_LOAD, OPC_STORE:  state_next = S_MEM;
               default:              state_next = S_FETCH;
            endcase
         end
         S_MEM:  if (mem_ready) state_next = (opcode == OPC_LOAD) ? S_WB : S_FETCH;
         S_WB:   state_next = S_FETCH;
         S_HALT: state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   mc_output_decode u_decode (
      .state     (state),
      .run       (run),
      .opcode    (opcode),
      .funct3    (funct3),
      .zero      (zero),
      .mem_ready (mem_ready),
      .ctrl      (dec_ctrl)
   );

   // Gating with rst_n drops a pending request the moment reset asserts, before any edge.
   assign ctrl = rst_n ? dec_ctrl : CTRL_IDLE;

   assign mem_req      = ctrl.mem_req;
   assign mem_we       = ctrl.mem_we;
   assign iord         = ctrl.iord;
   assign ir_write     = ctrl.ir_write;
   assign mdr_write    = ctrl.mdr_write;
   assign pc_write     = ctrl.pc_write;
   assign pc_src       = ctrl.pc_src;
   assign reg_write    = ctrl.reg_write;
   assign wb_sel       = ctrl.wb_sel;
   assign alu_src_a    = ctrl.alu_src_a;
   assign alu_src_b    = ctrl.alu_src_b;
   assign alu_op       = ctrl.alu_op;
   assign imm_sel      = ctrl.imm_sel;
   assign retire       = ctrl.retire;
   assign state_o      = state;
   assign pc_reset_val = RESET_PC;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, memory waits,
// reset during a store, and the illegal/HALT paths.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic [2:0]  funct3 = 3'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, iord, ir_write, mdr_write, pc_write, reg_write, retire, illegal;
   logic [1:0]  pc_src, wb_sel, alu_src_a, alu_src_b;
   logic [2:0]  alu_op, imm_sel, state_o;
   logic [31:0] pc_reset_val;

   int n_cmp = 0;
   int n_err = 0;

   multicycle_control #(.RESET_PC(32'h0000_1000)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .iord(iord), .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write),
      .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .retire(retire),
      .illegal(illegal), .state_o(state_o), .pc_reset_val(pc_reset_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with run = 1: outputs must still be idle.
      rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1;
      #3;
      check("rst_state",   32'(state_o), 0);
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_illegal", 32'(illegal), 0);
      check("rst_imm_sel", 32'(imm_sel), 0);
      check("rst_pc_val",  pc_reset_val, 32'h0000_1000);
      tick();
      check("rst_hold_state", 32'(state_o), 0);
      check("rst_hold_req",   32'(mem_req), 0);

      // ADDI x1, x0, 5 with zero-wait memory: F D E W.
      opcode = 7'h13; funct3 = 3'b000;
      rst_n = 1'b1;
      #1;
      check("addi_f_state", 32'(state_o), 0);
      check("addi_f_req",   32'(mem_req), 1);
      check("addi_f_iord",  32'(iord), 0);
      check("addi_f_irw",   32'(ir_write), 1);
      check("addi_f_pcw",   32'(pc_write), 1);
      check("addi_f_pcsrc", 32'(pc_src), 0);
      check("addi_f_srcb",  32'(alu_src_b), 1);
      check("addi_f_ret",   32'(retire), 0);
      tick();
      check("addi_d_state", 32'(state_o), 1);
      check("addi_d_srca",  32'(alu_src_a), 2);
      check("addi_d_srcb",  32'(alu_src_b), 2);
      check("addi_d_imm",   32'(imm_sel), 0);
      check("addi_d_rw",    32'(reg_write), 0);
      check("addi_d_req",   32'(mem_req), 0);
      tick();
      check("addi_e_state", 32'(state_o), 2);
      check("addi_e_srca",  32'(alu_src_a), 1);
      check("addi_e_srcb",  32'(alu_src_b), 2);
      check("addi_e_imm",   32'(imm_sel), 1);
      check("addi_e_aluop", 32'(alu_op), 0);
      check("addi_e_rw",    32'(reg_write), 0);
      check("addi_e_ret",   32'(retire), 0);
      tick();
      check("addi_w_state", 32'(state_o), 4);
      check("addi_w_rw",    32'(reg_write), 1);
      check("addi_w_wbsel", 32'(wb_sel), 0);
      check("addi_w_ret",   32'(retire), 1);
      tick();
      check("addi_done_state", 32'(state_o), 0);

      // LW with two wait cycles in FETCH and in MEM: 9 cycles total.
      opcode = 7'h03; mem_ready = 1'b0;
      #1;
      check("lw_f1_req",  32'(mem_req), 1);
      check("lw_f1_iord", 32'(iord), 0);
      check("lw_f1_irw",  32'(ir_write), 0);
      tick();
      check("lw_f2_state", 32'(state_o), 0);
      check("lw_f2_req",   32'(mem_req), 1);
      check("lw_f2_srcb",  32'(alu_src_b), 1);
      check("lw_f2_pcw",   32'(pc_write), 0);
      tick();
      mem_ready = 1'b1;
      #1;
      check("lw_f3_state", 32'(state_o), 0);
      check("lw_f3_irw",   32'(ir_write), 1);
      tick();
      check("lw_d_state", 32'(state_o), 1);
      tick();
      mem_ready = 1'b0;
      #1;
      check("lw_e_state", 32'(state_o), 2);
      check("lw_e_imm",   32'(imm_sel), 1);
      tick();
      check("lw_m1_state", 32'(state_o), 3);
      check("lw_m1_req",   32'(mem_req), 1);
      check("lw_m1_iord",  32'(iord), 1);
      check("lw_m1_we",    32'(mem_we), 0);
      check("lw_m1_mdrw",  32'(mdr_write), 0);
      tick();
      check("lw_m2_state", 32'(state_o), 3);
      check("lw_m2_req",   32'(mem_req), 1);
      check("lw_m2_iord",  32'(iord), 1);
      tick();
      mem_ready = 1'b1;
      #1;
      check("lw_m3_mdrw", 32'(mdr_write), 1);
      check("lw_m3_we",   32'(mem_we), 0);
      check("lw_m3_ret",  32'(retire), 0);
      tick();
      check("lw_w_state", 32'(state_o), 4);
      check("lw_w_wbsel", 32'(wb_sel), 1);
      check("lw_w_rw",    32'(reg_write), 1);
      check("lw_w_ret",   32'(retire), 1);
      tick();
      check("lw_done_state", 32'(state_o), 0);

      // BEQ taken with zero = 1.
      opcode = 7'h63; funct3 = 3'b000; zero = 1'b1;
      tick();
      check("beq_d_imm", 32'(imm_sel), 3);
      tick();
      check("beq_e_state", 32'(state_o), 2);
      check("beq_e_pcw",   32'(pc_write), 1);
      check("beq_e_pcsrc", 32'(pc_src), 1);
      check("beq_e_aluop", 32'(alu_op), 1);
      check("beq_e_ret",   32'(retire), 1);
      tick();
      check("beq_done_state", 32'(state_o), 0);

      // BNE not taken with zero = 1.
      funct3 = 3'b001;
      tick();
      tick();
      check("bne_e_state", 32'(state_o), 2);
      check("bne_e_pcw",   32'(pc_write), 0);
      check("bne_e_ret",   32'(retire), 1);
      tick();
      check("bne_done_state", 32'(state_o), 0);

      // JAL x1, +8.
      opcode = 7'h6F; funct3 = 3'b000; zero = 1'b0;
      tick();
      check("jal_d_imm", 32'(imm_sel), 4);
      tick();
      check("jal_e_pcw",   32'(pc_write), 1);
      check("jal_e_pcsrc", 32'(pc_src), 1);
      check("jal_e_rw",    32'(reg_write), 1);
      check("jal_e_wbsel", 32'(wb_sel), 2);
      check("jal_e_imm",   32'(imm_sel), 4);
      check("jal_e_aluop", 32'(alu_op), 3);
      check("jal_e_ret",   32'(retire), 1);
      tick();
      check("jal_done_state", 32'(state_o), 0);

      // SW with zero-wait memory: 4 cycles, retire in MEM.
      opcode = 7'h23; funct3 = 3'b010;
      tick();
      tick();
      check("sw_e_imm", 32'(imm_sel), 2);
      tick();
      check("sw_m_state", 32'(state_o), 3);
      check("sw_m_req",   32'(mem_req), 1);
      check("sw_m_we",    32'(mem_we), 1);
      check("sw_m_ret",   32'(retire), 1);
      tick();
      check("sw_done_state", 32'(state_o), 0);

      // Second SW, reset asserted while MEM is waiting.
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      check("swr_m_req", 32'(mem_req), 1);
      check("swr_m_we",  32'(mem_we), 1);
      tick();
      #2;
      rst_n = 1'b0; run = 1'b0;
      #1;
      check("swr_rst_req",   32'(mem_req), 0);
      check("swr_rst_we",    32'(mem_we), 0);
      check("swr_rst_state", 32'(state_o), 0);
      rst_n = 1'b1; mem_ready = 1'b1;
      tick();
      check("idle1_state", 32'(state_o), 0);
      check("idle1_req",   32'(mem_req), 0);
      tick();
      check("idle2_state", 32'(state_o), 0);
      check("idle2_req",   32'(mem_req), 0);

      // BRANCH with funct3 = 100 is illegal.
      opcode = 7'h63; funct3 = 3'b100; run = 1'b1;
      #1;
      check("run_resume_req", 32'(mem_req), 1);
      tick();
      check("ill_b_d_state",   32'(state_o), 1);
      check("ill_b_d_illegal", 32'(illegal), 0);
      tick();
      check("ill_b_state",   32'(state_o), 5);
      check("ill_b_illegal", 32'(illegal), 1);
      check("ill_b_req",     32'(mem_req), 0);
      tick();
      tick();
      check("ill_b_hold_state", 32'(state_o), 5);
      check("ill_b_hold_req",   32'(mem_req), 0);
      check("ill_b_hold_ill",   32'(illegal), 1);
      rst_n = 1'b0;
      #1;
      check("ill_clr_illegal", 32'(illegal), 0);
      check("ill_clr_state",   32'(state_o), 0);
      rst_n = 1'b1;

      // Unsupported opcode 0x7F.
      opcode = 7'h7F; funct3 = 3'b000;
      tick();
      tick();
      check("ill_o_state",   32'(state_o), 5);
      check("ill_o_illegal", 32'(illegal), 1);
      tick();
      check("ill_o_req",     32'(mem_req), 0);
      check("ill_o_retire",  32'(retire), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
